// File: rtl/regfile_readback_if.sv
// rtl/regfile_readback_if.sv - start/status, register-file read port and output stream bundle
interface regfile_readback_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              busy;
    logic              done;
    logic              err;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        input  start, first_addr, last_addr, rd_data, out_ready,
        output busy, done, err, rd_en, rd_addr, out_valid, out_data, out_addr
    );

    modport slave (
        output start, first_addr, last_addr, rd_data, out_ready,
        input  busy, done, err, rd_en, rd_addr, out_valid, out_data, out_addr
    );
endinterface

// File: rtl/regfile_readback.sv
// rtl/regfile_readback.sv - walks an inclusive register range and streams address-tagged words
module regfile_readback #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    regfile_readback_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPT, S_SEND, S_DONE, S_ERR
    } state_t;

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    state_t            state_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [ADDR_W-1:0] end_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;

    logic              range_ok;
    logic [ADDR_W-1:0] next_addr;

    assign range_ok  = (bus.first_addr <= bus.last_addr) &&
                       ({1'b0, bus.last_addr} < NUM_REGS_W);
    assign next_addr = cur_addr_q + ADDR_W'(1);

    // Outputs are registered: each branch sets the values seen in the state it enters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= '0;
            end_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (range_ok) begin
                            cur_addr_q <= bus.first_addr;
                            end_addr_q <= bus.last_addr;
                            rd_en_q    <= 1'b1;
                            rd_addr_q  <= bus.first_addr;
                            state_q    <= S_READ;
                        end else begin
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= S_ERR;
                        end
                    end
                end
                S_READ: state_q <= S_CAPT;
                S_CAPT: begin
                    out_data_q  <= bus.rd_data;
                    out_addr_q  <= cur_addr_q;
                    out_valid_q <= 1'b1;
                    state_q     <= S_SEND;
                end
                S_SEND: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (cur_addr_q == end_addr_q) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            cur_addr_q <= next_addr;
                            rd_en_q    <= 1'b1;
                            rd_addr_q  <= next_addr;
                            state_q    <= S_READ;
                        end
                    end
                end
                S_DONE, S_ERR: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_addr  = out_addr_q;
endmodule

// File: tb/tb_regfile_readback.sv
// tb/tb_regfile_readback.sv - directed bench for regfile_readback
module tb_regfile_readback;
    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic [DATA_W-1:0] regs [64];

    regfile_readback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_readback #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous-read register file behind the read port.
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= regs[bus.rd_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input int first, input int last);
        bus.first_addr = ADDR_W'(first);
        bus.last_addr  = ADDR_W'(last);
        bus.start      = 1'b1;
        tick();
        bus.start      = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(bus.busy), 64'(0));
        check({tag, "_done"},  64'(bus.done), 64'(0));
        check({tag, "_err"},   64'(bus.err), 64'(0));
        check({tag, "_rd_en"}, 64'(bus.rd_en), 64'(0));
        check({tag, "_rd_addr"}, 64'(bus.rd_addr), 64'(0));
        check({tag, "_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_data"},  64'(bus.out_data), 64'(0));
        check({tag, "_addr"},  64'(bus.out_addr), 64'(0));
    endtask

    // Called at the cycle-1 sample point after a start; expects regs[i] = 0x1000_0000 + i.
    task automatic drain(input int first, input int n, input int exp_done, input int budget,
                         input bit rnd, input int glitch);
        int got = 0;
        int dcnt = 0;
        int dcyc = 0;
        int viol = 0;
        bit stalled = 1'b0;
        logic [DATA_W-1:0] pd = '0;
        logic [ADDR_W-1:0] pa = '0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            bus.start = (cyc == glitch);
            if (cyc == glitch) begin
                bus.first_addr = ADDR_W'(10);
                bus.last_addr  = ADDR_W'(20);
            end
            if (bus.rd_en && bus.out_valid) viol++;
            if (bus.rd_en) check("rd_addr", 64'(bus.rd_addr), 64'(first + got));
            if (stalled) begin
                check("stall_valid", 64'(bus.out_valid), 64'(1));
                check("stall_data", 64'(bus.out_data), 64'(pd));
                check("stall_addr", 64'(bus.out_addr), 64'(pa));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("word_addr", 64'(bus.out_addr), 64'(first + got));
                check("word_data", 64'(bus.out_data), 64'(32'h1000_0000 + first + got));
                if (!rnd) check("word_cycle", 64'(cyc), 64'(3 + 3 * got));
                got++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            pd = bus.out_data;
            pa = bus.out_addr;
            if (bus.done) begin
                dcnt++;
                dcyc = cyc;
                check("done_err", 64'(bus.err), 64'(0));
                break;
            end
            tick();
        end
        bus.start = 1'b0;
        check("word_count", 64'(got), 64'(n));
        check("done_count", 64'(dcnt), 64'(1));
        if (exp_done > 0) check("done_cycle", 64'(dcyc), 64'(exp_done));
        check("rd_en_in_send", 64'(viol), 64'(0));
    endtask

    initial begin
        int rd_seen;
        bus.start = 1'b0;
        bus.first_addr = '0;
        bus.last_addr = '0;
        bus.out_ready = 1'b0;
        bus.rd_data = '0;
        for (int i = 0; i < 64; i++) regs[i] = 32'h1000_0000 + i;

        // Reset and idle
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        rd_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rd_en || bus.busy) rd_seen++;
        end
        check("idle_quiet", 64'(rd_seen), 64'(0));

        // Single word 7..7
        regs[7] = 32'hDEADBEEF;
        bus.out_ready = 1'b1;
        issue(7, 7);
        check("sw_c1_rd_en", 64'(bus.rd_en), 64'(1));
        check("sw_c1_rd_addr", 64'(bus.rd_addr), 64'(7));
        check("sw_c1_busy", 64'(bus.busy), 64'(1));
        tick();
        check("sw_c2_rd_en", 64'(bus.rd_en), 64'(0));
        check("sw_c2_rd_addr", 64'(bus.rd_addr), 64'(0));
        check("sw_c2_valid", 64'(bus.out_valid), 64'(0));
        tick();
        check("sw_c3_valid", 64'(bus.out_valid), 64'(1));
        check("sw_c3_data", 64'(bus.out_data), 64'(32'hDEADBEEF));
        check("sw_c3_addr", 64'(bus.out_addr), 64'(7));
        tick();
        check("sw_c4_done", 64'(bus.done), 64'(1));
        check("sw_c4_err", 64'(bus.err), 64'(0));
        check("sw_c4_valid", 64'(bus.out_valid), 64'(0));
        tick();
        check("sw_c5_done", 64'(bus.done), 64'(0));
        check("sw_c5_busy", 64'(bus.busy), 64'(0));
        regs[7] = 32'h1000_0007;

        // Full dump 0..31
        issue(0, 31);
        drain(0, 32, 97, 120, 1'b0, 0);
        tick();
        check("full_after_done", 64'(bus.done), 64'(0));
        check("full_after_busy", 64'(bus.busy), 64'(0));

        // Backpressure 3..5
        issue(3, 5);
        drain(3, 3, 0, 200, 1'b1, 0);
        bus.out_ready = 1'b1;
        tick();

        // Rejected ranges
        issue(9, 4);
        check("bad1_done", 64'(bus.done), 64'(1));
        check("bad1_err", 64'(bus.err), 64'(1));
        check("bad1_busy", 64'(bus.busy), 64'(1));
        check("bad1_rd_en", 64'(bus.rd_en), 64'(0));
        check("bad1_valid", 64'(bus.out_valid), 64'(0));
        tick();
        check("bad1_c2_busy", 64'(bus.busy), 64'(0));
        check("bad1_c2_done", 64'(bus.done), 64'(0));
        check("bad1_c2_rd_en", 64'(bus.rd_en), 64'(0));
        issue(0, 32);
        check("bad2_done", 64'(bus.done), 64'(1));
        check("bad2_err", 64'(bus.err), 64'(1));
        check("bad2_busy", 64'(bus.busy), 64'(1));
        check("bad2_rd_en", 64'(bus.rd_en), 64'(0));
        check("bad2_valid", 64'(bus.out_valid), 64'(0));
        tick();
        check("bad2_c2_busy", 64'(bus.busy), 64'(0));
        check("bad2_c2_valid", 64'(bus.out_valid), 64'(0));

        // Reset while SEND is stalled
        bus.out_ready = 1'b0;
        issue(0, 31);
        tick();
        tick();
        check("rs_c3_valid", 64'(bus.out_valid), 64'(1));
        check("rs_c3_data", 64'(bus.out_data), 64'(32'h1000_0000));
        tick();
        tick();
        check("rs_stalled_valid", 64'(bus.out_valid), 64'(1));
        check("rs_stalled_addr", 64'(bus.out_addr), 64'(0));
        rst = 1'b1;
        #1;
        check_all_zero("rs_async");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("rs_held");
        bus.out_ready = 1'b1;
        tick();
        check_all_zero("rs_idle");

        // Start during a dump and during done is ignored; start right after done is taken
        issue(2, 3);
        drain(2, 2, 7, 40, 1'b0, 1);
        issue(5, 5);
        check("done_start_busy", 64'(bus.busy), 64'(0));
        check("done_start_rd_en", 64'(bus.rd_en), 64'(0));
        issue(5, 5);
        check("restart_rd_en", 64'(bus.rd_en), 64'(1));
        check("restart_rd_addr", 64'(bus.rd_addr), 64'(5));
        drain(5, 1, 4, 20, 1'b0, 0);
        tick();
        check("final_busy", 64'(bus.busy), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_readback.md
# regfile_readback

Register readback sequencer: the read side for the core's write-enabled 32-bit register storage. On a `start` pulse it walks an inclusive address range of the register file through a synchronous read port and streams each word, tagged with its address, out over a valid/ready interface. It serves debug and state-dump paths, so register contents can be drained without stalling the write side.

## Interface
- `NUM_REGS`, 32, number of addressable registers
- `DATA_W`, 32, register data width
- `ADDR_W`, 5, address width; must satisfy 2^ADDR_W >= NUM_REGS

- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  single-cycle request to begin a dump; sampled only in IDLE
- `first_addr`  in  ADDR_W  first register address; sampled with `start`
- `last_addr`  in  ADDR_W  last register address, inclusive; sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of a dump or on a rejected request
- `err`  out  1  one-cycle pulse, coincident with `done`, on a rejected request
- `rd_en`  out  1  register-file read strobe
- `rd_addr`  out  ADDR_W  register-file read address
- `rd_data`  in  DATA_W  register-file read data, valid the cycle after `rd_en`
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  downstream accepts the word when high with `out_valid`
- `out_data`  out  DATA_W  register contents
- `out_addr`  out  ADDR_W  address the `out_data` word was read from

## Operation
- Moore FSM, states IDLE, READ, CAPT, SEND, DONE, ERR. Internal `cur_addr` and `end_addr` registers.
- IDLE: if `start` and `first_addr <= last_addr` and `last_addr < NUM_REGS`, load `cur_addr`=`first_addr` and `end_addr`=`last_addr`, then go to READ. If `start` with an invalid range, go to ERR. Otherwise stay in IDLE.
- READ: `rd_en`=1 and `rd_addr`=`cur_addr` for exactly one cycle, then go to CAPT.
- CAPT: register `out_data`<=`rd_data` and `out_addr`<=`cur_addr`, then go to SEND.
- SEND: `out_valid`=1. `out_data` and `out_addr` are held stable until accepted.
  - On `out_ready`, if `cur_addr==end_addr` go to DONE.
  - Otherwise `cur_addr`<=`cur_addr`+1 and go to READ.
- DONE: `done`=1 for one cycle, then go to IDLE.
- ERR: `done`=1 and `err`=1 for one cycle, then go to IDLE. No read is issued.
- `start` in any state other than IDLE is ignored. Range inputs are not re-sampled during a dump.
- `cur_addr` never wraps: the range check guarantees that the increment stays at or below `end_addr`.
- `out_valid` never deasserts without a handshake. `rd_en` is never asserted outside READ.
- `rd_addr` is 0 whenever `rd_en`=0.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `cur_addr`/`end_addr`/`out_data`/`out_addr` all 0.
- Reset asserted mid-dump returns the block to IDLE immediately. The in-flight word is discarded and no `done` is produced.
- With `start` sampled at edge 0 and `out_ready` held high:
  - READ in cycle 1, CAPT in cycle 2, SEND in cycle 3.
  - Each word takes 3 cycles, so word k has `out_valid` in cycle 3+3k.
  - For N words, `done` is high in cycle 3N+1.
- Each cycle of SEND with `out_ready` low adds one cycle of delay.
- A rejected request gives `done`=`err`=1 in cycle 1, with `busy`=1 in that cycle only.
- `start` can be accepted again in the cycle after `done` (IDLE).
- `start` arriving in the same cycle as `done` is ignored.

## Test plan
- Reset, then check idle outputs: every output is 0, `busy`=0, and no `rd_en` appears over 10 cycles.
- Single word: preload reg 7 with 0xDEADBEEF, `start` with range 7..7, ready high. Required: `rd_en`/`rd_addr`=7 in cycle 1, `out_valid` with 0xDEADBEEF/7 in cycle 3, `done` in cycle 4.
- Full dump: preload reg i with 0x1000_0000+i, range 0..31, ready high. Required: 32 words in ascending order with the matching data, exactly one `done`, in cycle 97.
- Backpressure: range 3..5, `out_ready` random (about 50%). Required: words 3, 4, 5 each stable while stalled, with no loss or duplication, and no `rd_en` while in SEND.
- Bad ranges: `start` with 9..4, then 0..32 (with `ADDR_W`=6, `NUM_REGS`=32). Required: each gives `done`=`err`=1 in cycle 1, with no `rd_en` and no `out_valid`.
- Reset and ignored start: pulse `rst` while SEND is stalled in a 0..31 dump. Required: IDLE next cycle with every output 0 and no `done`. Then a `start` issued during a dump has no effect on that dump.
